// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I front end.
package rv32i_pkg;

    // Fetch sequencer: issue a request, wait for its response, or wait
    // for a response that must be thrown away.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    // ADDI x0,x0,0 -- shown to decode whenever no instruction is valid.
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Default architectural PC after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are word aligned: two ignored address bits, 4-byte step.
    localparam int ALIGN_BITS = 2;
    localparam int PC_STEP    = 4;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect decode: detects a control-flow change resolved downstream and
// forms the word-aligned target it redirects to.
module next_pc_sel
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Branch,
    input  logic                  branch_result,
    input  logic                  next_sel,
    input  logic                  Jalr,
    input  logic [DATA_WIDTH-1:0] target,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    // The low target bits never reach the PC; keep them visibly consumed.
    logic unused_target_bits;
    assign unused_target_bits = ^target[ALIGN_BITS-1:0];

    // Taken branch, JAL or JALR all redirect fetch.
    assign redirect    = (Branch & branch_result) | next_sel | Jalr;
    assign redirect_pc = {target[DATA_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, keeps one request in flight to a
// variable-latency instruction memory, and hands the returned word to decode
// through a valid/ready register. Redirects flush the output register and
// cause the in-flight response to be dropped.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     INSTRUCTION = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC    = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter logic [INSTRUCTION-1:0] NOP_INSTR   = INSTRUCTION'(NOP_WORD)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic [INSTRUCTION-1:0] imem_rdata,
    input  logic                   imem_valid,
    input  logic                   Branch,
    input  logic                   branch_result,
    input  logic                   next_sel,
    input  logic                   Jalr,
    input  logic [DATA_WIDTH-1:0]  target,
    input  logic                   decode_ready,
    output logic [INSTRUCTION-1:0] instruction,
    output logic [DATA_WIDTH-1:0]  pc,
    output logic                   inst_valid
);

    fetch_state_t          state, state_next;
    logic [DATA_WIDTH-1:0] pc_q, pc_next;
    logic                  load;
    logic                  slot_free;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;

    next_pc_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_pc_sel (
        .Branch        (Branch),
        .branch_result (branch_result),
        .next_sel      (next_sel),
        .Jalr          (Jalr),
        .target        (target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    // A new word may be fetched only if the output register will be empty.
    assign slot_free = !inst_valid || decode_ready;
    assign imem_addr = pc_q;

    // Next state, request strobe and PC update; redirect overrides all.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_next = state;
        pc_next    = pc_q;
        imem_req   = 1'b0;
        load       = 1'b0;

        case (state)
            S_REQ: begin
                if (slot_free) begin
                    imem_req   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    load       = 1'b1;
                    pc_next    = pc_q + DATA_WIDTH'(PC_STEP);
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase

        if (redirect) begin
            load    = 1'b0;
            pc_next = redirect_pc;
            if (state == S_REQ) begin
                // A request leaving this cycle still owes a response.
                state_next = imem_req ? S_DROP : S_REQ;
            end else begin
                state_next = imem_valid ? S_REQ : S_DROP;
            end
        end

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // State register; reset keeps track of a response still owed by memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            case (state)
                // A response arriving in the reset cycle itself settles the debt.
                S_WAIT, S_DROP: state <= imem_valid ? S_REQ : S_DROP;
                default:        state <= S_REQ;
            endcase
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state <= state_next;
        end
    end

    // Architectural PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Output register towards decode: flush, load, consume or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= NOP_INSTR;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
        end else if (redirect) begin
            instruction <= NOP_INSTR;
            inst_valid  <= 1'b0;
        end else if (load) begin
            instruction <= imem_rdata;
            pc          <= pc_q;
            inst_valid  <= 1'b1;
        end else if (inst_valid && decode_ready) begin
            instruction <= NOP_INSTR;
            inst_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a latency-programmable memory model,
// a scoreboard of the expected instruction stream, directed scenarios and a
// randomized phase.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        Branch, branch_result, next_sel, Jalr;
    logic [31:0] target;
    logic        decode_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        inst_valid;

    always #5 clk = ~clk;

    fetch_stage #(
        .DATA_WIDTH  (32),
        .INSTRUCTION (32),
        .RESET_PC    (RST_PC),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .Branch        (Branch),
        .branch_result (branch_result),
        .next_sel      (next_sel),
        .Jalr          (Jalr),
        .target        (target),
        .decode_ready  (decode_ready),
        .instruction   (instruction),
        .pc            (pc),
        .inst_valid    (inst_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a distinct word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + 32'h0BAD_0000;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    bit          flush_pending = 0;
    logic [31:0] flush_base;

    // After reset or a redirect, decode must see base, base+4, ... in order.
    task automatic refill(input logic [31:0] base);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            e.pc    = base + 32'(4 * i);
            e.instr = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- memory model ----------------
    int          lat_cfg = 1;
    bit          mem_pending = 0;
    int          mem_cnt;
    logic [31:0] mem_addr;

    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                check("one_outstanding", 32'(mem_pending), 32'd0);
                check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
                mem_pending = 1'b1;
                mem_cnt     = lat_cfg;
                mem_addr    = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_valid  = 1'b1;
                    imem_rdata  = mem_word(mem_addr);
                    mem_pending = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic        redirect_in;
    bit          prev_stall = 0;
    logic [31:0] prev_pc, prev_ins;

    assign redirect_in = (Branch & branch_result) | next_sel | Jalr;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (inst_valid === 1'b1 && decode_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty: consumed pc 0x%08h with nothing expected", pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", pc, e.pc);
                        check("sb_instr", instruction, e.instr);
                    end
                end else if (inst_valid !== 1'b1) begin
                    check("nop_when_invalid", instruction, NOP);
                end
                if (inst_valid === 1'b1 && decode_ready === 1'b0)
                    check("no_req_in_stall", 32'(imem_req), 32'd0);
                if (prev_stall) begin
                    check("stall_hold_valid", 32'(inst_valid), 32'd1);
                    check("stall_hold_pc", pc, prev_pc);
                    check("stall_hold_instr", instruction, prev_ins);
                end
            end
            prev_stall = (rst === 1'b0) && (inst_valid === 1'b1) && (decode_ready === 1'b0)
                         && (redirect_in === 1'b0);
            prev_pc    = pc;
            prev_ins   = instruction;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
        if (flush_pending) begin
            refill(flush_base);
            flush_pending = 0;
        end
    endtask

    task automatic idle();
        Branch        = 1'b0;
        branch_result = 1'b0;
        next_sel      = 1'b0;
        Jalr          = 1'b0;
        target        = 32'h0;
    endtask

    task automatic note_redirect(input logic [31:0] tgt);
        flush_pending = 1;
        flush_base    = {tgt[31:2], 2'b00};
    endtask

    task automatic wait_req(input string name);
        bit seen = 0;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (imem_req === 1'b1) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: no request within 30 cycles", name);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen = 0;
        for (int n = 0; n < 30; n++) begin
            if (inst_valid === 1'b1) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: no valid output within 30 cycles", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_instr"}, instruction, NOP);
        check({tag, "_pc"}, pc, RST_PC);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scenarios ----------------
    initial begin
        logic [31:0] held;
        int          n;
        bit          tk;

        rst          = 1'b1;
        decode_ready = 1'b1;
        idle();
        lat_cfg = 1;

        // Reset values and the first request.
        step();
        check_reset_outputs("reset1");
        step();
        check_reset_outputs("reset2");
        rst = 1'b0;
        refill(RST_PC);
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_req_addr", imem_addr, RST_PC);

        // 1-cycle memory: one instruction every two cycles, through the wrap.
        wait_valid("rate_start");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid === 1'b1) n++;
            step();
        end
        check("rate_two_cycles", 32'(n), 32'd10);

        // Stall: outputs hold, no request, then fetch resumes sequentially.
        wait_valid("stall_start");
        held = pc;
        decode_ready = 1'b0;
        repeat (5) step();
        check("stall_pc_after", pc, held);
        decode_ready = 1'b1;
        #1;
        check("release_req", 32'(imem_req), 32'd1);
        check("release_addr", imem_addr, held + 32'd4);
        repeat (4) step();

        // JALR while waiting on a 3-cycle memory.
        lat_cfg = 3;
        wait_req("jalr_req");
        step();
        Jalr   = 1'b1;
        target = 32'h0000_0101;
        note_redirect(target);
        step();
        idle();
        wait_req("jalr_refetch");
        check("jalr_addr", imem_addr, 32'h0000_0100);
        wait_valid("jalr_out");
        check("jalr_first_pc", pc, 32'h0000_0100);
        repeat (6) step();

        // Branch not taken, then taken.
        lat_cfg = 1;
        repeat (3) step();
        Branch        = 1'b1;
        branch_result = 1'b0;
        target        = 32'h0000_3000;
        step();
        idle();
        repeat (6) step();
        Branch        = 1'b1;
        branch_result = 1'b1;
        target        = 32'h0000_0040;
        note_redirect(target);
        step();
        idle();
        wait_req("branch_refetch");
        check("branch_addr", imem_addr, 32'h0000_0040);
        repeat (6) step();

        // JAL in the very cycle the response returns.
        lat_cfg = 2;
        repeat (4) step();
        tk = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (imem_valid === 1'b1) begin
                tk = 1;
                break;
            end
            step();
        end
        check("coincide_found", 32'(tk), 32'd1);
        next_sel = 1'b1;
        target   = 32'h0000_0200;
        note_redirect(target);
        step();
        idle();
        check("coincide_flush", 32'(inst_valid), 32'd0);
        #1;
        check("coincide_req", 32'(imem_req), 32'd1);
        check("coincide_addr", imem_addr, 32'h0000_0200);
        repeat (8) step();

        // Reset while a 4-cycle response is outstanding.
        lat_cfg = 4;
        wait_req("rst_req");
        step();
        rst = 1'b1;
        step();
        check_reset_outputs("midreset");
        rst = 1'b0;
        refill(RST_PC);
        #1;
        check("midreset_no_req", 32'(imem_req), 32'd0);
        wait_valid("midreset_out");
        check("midreset_first_pc", pc, RST_PC);
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            lat_cfg       = int'($urandom_range(1, 4));
            decode_ready  = ($urandom_range(0, 9) < 7);
            n             = int'($urandom_range(0, 99));
            rst           = (n == 0);
            Branch        = ($urandom_range(0, 7) == 0);
            branch_result = $urandom_range(0, 1) == 1;
            next_sel      = (n == 1 || n == 2);
            Jalr          = (n == 3 || n == 4);
            target        = $urandom;
            if (rst) begin
                flush_pending = 1;
                flush_base    = RST_PC;
            end else if ((Branch && branch_result) || next_sel || Jalr) begin
                note_redirect(target);
            end
            step();
        end

        rst = 1'b0;
        idle();
        decode_ready = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Holds the architectural PC and issues one request at a time to a variable-latency instruction memory.
- Registers the returned instruction and its PC for decode, using a valid/ready handshake.
- Applies control-flow redirects from downstream (taken branch, JAL, JALR) and discards stale in-flight responses.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and redirect target.
- INSTRUCTION, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven while the output is invalid (ADDI x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- imem_req  out  1  request strobe; the memory always accepts the request in the cycle it is asserted.
- imem_addr  out  DATA_WIDTH  request address, word aligned.
- imem_rdata  in  INSTRUCTION  returned instruction word.
- imem_valid  in  1  rdata valid; exactly one response per request, at least 1 cycle after the request.
- Branch  in  1  branch instruction resolving this cycle.
- branch_result  in  1  branch taken.
- next_sel  in  1  JAL redirect.
- Jalr  in  1  JALR redirect.
- target  in  DATA_WIDTH  redirect target computed downstream.
- decode_ready  in  1  decode accepts instruction this cycle.
- instruction  out  INSTRUCTION  instruction to decode.
- pc  out  DATA_WIDTH  PC of the output instruction.
- inst_valid  out  1  instruction/pc valid.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pc_q = RESET_PC; state = S_REQ.
  - instruction = NOP_INSTR; pc = RESET_PC; inst_valid = 0.
  - imem_req = 0 during the reset cycle.
- Reset mid-transaction: any outstanding response is ignored. imem_valid arriving in the cycle after reset is dropped, because the stage enters S_DROP if it was in S_WAIT/S_DROP when reset was asserted.
- Redirect decode: redirect = (Branch & branch_result) | next_sel | Jalr. The redirect PC is {target[DATA_WIDTH-1:2], 2'b00}; the low two bits are always ignored.
- Handshake: an instruction is consumed at a clock edge where inst_valid & decode_ready.
- Output slot free condition: slot_free = !inst_valid | decode_ready.
- State machine:
  - S_REQ: if slot_free, drive imem_req=1 and imem_addr=pc_q, then go to S_WAIT. Otherwise imem_req=0 and stay. imem_addr always shows pc_q.
  - S_WAIT: imem_req=0. On imem_valid:
    - load instruction=imem_rdata, pc=pc_q, inst_valid=1;
    - pc_q = pc_q + 4, modulo 2^DATA_WIDTH (32'hFFFF_FFFC wraps to 0);
    - go to S_REQ.
  - S_DROP: imem_req=0. On imem_valid, discard the data and go to S_REQ.
- Consumption without a new load: inst_valid clears and instruction returns to NOP_INSTR.
- Redirect (highest priority, any state):
  - inst_valid=0 and instruction=NOP_INSTR next cycle, even if decode_ready is high that cycle.
  - pc_q = redirect PC.
  - Next state:
    - S_REQ issuing → S_DROP;
    - S_WAIT without imem_valid → S_DROP;
    - S_WAIT with imem_valid → S_REQ (the response is discarded);
    - S_DROP → stays S_DROP, or S_REQ if imem_valid arrives the same cycle;
    - S_REQ not issuing → S_REQ.
- Throughput and latency:
  - Peak rate is one instruction per (memory latency + 1) cycles.
  - First request is issued in the cycle after reset deasserts.
  - Only one outstanding request at any time.
- Stall: instruction, pc and inst_valid hold stable while inst_valid & !decode_ready. No request is issued in that case.

Decomposition:
- Package rv32i_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_DROP};
  - NOP_INSTR constant;
  - RESET_PC default.
- One sub-module: next_pc_sel, purely combinational. It computes redirect and redirect_pc from Branch/branch_result/next_sel/Jalr/target.
- The FSM, PC register and output register stay in fetch_stage.

Test Plan:
- Reset then 1-cycle memory, decode_ready=1:
  - requests are issued at 0x0, 0x4, 0x8;
  - inst_valid pulses every 2 cycles with matching pc and rdata;
  - instruction=0x13 between pulses.
- Stall: decode_ready=0 for 5 cycles after the instruction at 0x4 is loaded.
  - instruction/pc hold at 0x4 and imem_req stays 0.
  - On release the next request is issued at 0x8.
- Redirect during S_WAIT with 3-cycle latency: Jalr=1, target=0x101.
  - The response for the old address is dropped and inst_valid stays 0.
  - The next request is issued at 0x100.
  - The first valid output is pc=0x100.
- Branch not taken vs taken:
  - Branch=1, branch_result=0: no redirect, sequential fetch continues.
  - Branch=1, branch_result=1, target=0x40: the output is flushed and the next fetch is at 0x40.
- Redirect coincident with imem_valid and decode_ready=1: next_sel=1, target=0x200.
  - The returned word is discarded and inst_valid is 0 next cycle.
  - A request to 0x200 is issued the following cycle with no S_DROP wait.
- Wrap-around: RESET_PC=32'hFFFF_FFFC.
  - The first fetch is at 0xFFFF_FFFC and the second at 0x0000_0000.
  - Asserting rst mid-S_WAIT returns pc to RESET_PC, and the late response is discarded.
